// File: rtl/ram_store_writer.sv
// 16x8 RAM with its own MAR on the shared bus w, plus a program-mode loader
// that streams bytes into consecutive addresses over a valid/ready handshake.
module ram_store_writer #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              lm,
    input  logic              er,
    input  logic              lr,
    inout  wire  [DATA_W-1:0] w,
    input  logic              prog,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_mar;
    logic [ADDR_W-1:0] r_load_addr;
    logic              w_run;
    logic              w_xfer;
    logic              w_last;
    logic              w_rd_en;

    // Bus strobes only act outside the loader and while no load is requested.
    assign w_run    = (r_state != LOAD) && !prog;
    assign in_ready = (r_state == LOAD) && prog;
    assign w_xfer   = in_ready && in_valid;
    assign w_last   = (r_load_addr == ADDR_W'(DEPTH - 1));
    // A simultaneous write suppresses the read so we never drive our own write data.
    assign w_rd_en  = w_run && er && !lr;
    assign w        = w_rd_en ? r_mem[r_mar] : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (prog) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (!prog) begin
                    w_state_nxt = IDLE;
                end else if (w_xfer && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!prog) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_mar       <= '0;
            r_load_addr <= '0;
            load_count  <= '0;
            load_done   <= 1'b0;
        end else begin
            if (w_run && lm) begin
                r_mar <= w[ADDR_W-1:0];
            end
            if ((r_state == IDLE) && prog) begin
                r_load_addr <= '0;
                load_count  <= '0;
                load_done   <= 1'b0;
            end else if (w_xfer) begin
                r_load_addr <= r_load_addr + 1'b1;
                if (load_count < (ADDR_W + 1)'(DEPTH)) begin
                    load_count <= load_count + 1'b1;
                end
                if (w_last) begin
                    load_done <= 1'b1;
                end
            end
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[r_load_addr] <= in_data;
        end else if (w_run && lr) begin
            r_mem[r_mar] <= w;
        end
    end

endmodule

// File: tb/tb_ram_store_writer.sv
// Scoreboard bench for ram_store_writer: stimulus queues expected status and
// bus reads; a negedge monitor pops and compares them.
module tb_ram_store_writer;

    logic       clk;
    logic       clr_n;
    logic       lm;
    logic       er;
    logic       lr;
    wire  [7:0] w;
    logic       prog;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       load_done;
    logic [4:0] load_count;

    logic       tb_drv_en;
    logic [7:0] tb_w;

    assign w = tb_drv_en ? tb_w : 8'bzzzz_zzzz;

    ram_store_writer dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .lm         (lm),
        .er         (er),
        .lr         (lr),
        .w          (w),
        .prog       (prog),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_done  (load_done),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       rdy;
        logic       done;
        logic [4:0] cnt;
        logic       drv;
    } st_t;

    typedef struct {
        string      nm;
        logic [7:0] v;
    } rd_t;

    st_t st_q[$];
    rd_t rd_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    always @(negedge clk) begin
        st_t e;
        rd_t r;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            n_chk++;
            if ({in_ready, load_done, load_count, dut.w_rd_en} !== {e.rdy, e.done, e.cnt, e.drv}) begin
                n_fail++;
                $display("FAIL %s: got rdy=%0b done=%0b cnt=%0d drv=%0b, want rdy=%0b done=%0b cnt=%0d drv=%0b",
                         e.nm, in_ready, load_done, load_count, dut.w_rd_en, e.rdy, e.done, e.cnt, e.drv);
            end
        end
        if (er && !lr && !prog) begin
            n_chk++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got w=%02h, want no read pending", w);
            end else begin
                r = rd_q.pop_front();
                if (w !== r.v || dut.w_rd_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s: got w=%02h drv=%0b, want w=%02h drv=1", r.nm, w, dut.w_rd_en, r.v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_st(input string nm, input logic rdy, input logic done,
                          input logic [4:0] cnt, input logic drv);
        st_t e;
        e.nm = nm; e.rdy = rdy; e.done = done; e.cnt = cnt; e.drv = drv;
        st_q.push_back(e);
    endtask

    task automatic exp_rd(input string nm, input logic [7:0] v);
        rd_t r;
        r.nm = nm; r.v = v;
        rd_q.push_back(r);
    endtask

    task automatic drive(input logic [7:0] v);
        tb_w      = v;
        tb_drv_en = 1'b1;
    endtask

    task automatic undrive();
        tb_drv_en = 1'b0;
    endtask

    // Latch an address into MAR, then read it back on the following cycle.
    task automatic rd(input logic [3:0] a, input logic [7:0] v, input string nm);
        lm = 1'b1;
        drive({4'h0, a});
        tick();
        lm = 1'b0;
        undrive();
        er = 1'b1;
        exp_rd(nm, v);
        tick();
        er = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n = 1'b0; lm = 1'b0; er = 1'b0; lr = 1'b0; prog = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; tb_drv_en = 1'b0; tb_w = 8'h00;
        #1;
        exp_st("reset_hold", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        tick();
        clr_n = 1'b1;
        exp_st("after_reset", 1'b0, 1'b0, 5'd0, 1'b0);

        // Run-mode write at reset MAR (0), read back, then confirm via explicit address 0
        drive(8'h5A);
        lr = 1'b1;
        tick();
        lr = 1'b0;
        undrive();
        er = 1'b1;
        exp_rd("rd_mar_reset", 8'h5A);
        tick();
        er = 1'b0;
        rd(4'd0, 8'h5A, "rd_addr0_first");

        // Full load 0x10..0x1F
        prog = 1'b1; in_valid = 1'b1; in_data = 8'h10;
        exp_st("load_entry_idle", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(8'h10 + i);
            exp_st($sformatf("full_load_%0d", i), 1'b1, 1'b0, 5'(i), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        exp_st("full_done", 1'b0, 1'b1, 5'd16, 1'b0);
        tick();
        exp_st("done_hold_prog", 1'b0, 1'b1, 5'd16, 1'b0);
        prog = 1'b0;
        tick();
        exp_st("done_after_drop", 1'b0, 1'b1, 5'd16, 1'b0);
        rd(4'd5, 8'h15, "rd_full_5");
        rd(4'd15, 8'h1F, "rd_full_15");

        // Handshake stalls
        prog = 1'b1;
        tick();
        exp_st("stall_entry", 1'b1, 1'b0, 5'd0, 1'b0);
        in_valid = 1'b1; in_data = 8'hAA; tick();
        in_valid = 1'b0; in_data = 8'hBB; tick();
        in_valid = 1'b0; in_data = 8'hCC; tick();
        in_valid = 1'b1; in_data = 8'hDD; tick();
        in_valid = 1'b0;
        exp_st("stall_count", 1'b1, 1'b0, 5'd2, 1'b0);
        tick();
        prog = 1'b0;
        tick();
        exp_st("stall_abort", 1'b0, 1'b0, 5'd2, 1'b0);
        rd(4'd0, 8'hAA, "rd_stall_0");
        rd(4'd1, 8'hDD, "rd_stall_1");
        rd(4'd2, 8'h12, "rd_stall_2");

        // Abort after 5 transfers with in_valid high on the drop edge
        prog = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + i);
            tick();
        end
        prog = 1'b0; in_valid = 1'b1; in_data = 8'h99;
        exp_st("abort_edge", 1'b0, 1'b0, 5'd5, 1'b0);
        tick();
        in_valid = 1'b0;
        exp_st("abort_idle", 1'b0, 1'b0, 5'd5, 1'b0);
        rd(4'd5, 8'h15, "rd_abort_5");
        rd(4'd4, 8'h44, "rd_abort_4");

        // Run-mode write with simultaneous MAR load
        lm = 1'b1; drive(8'h03); tick();
        lm = 1'b1; lr = 1'b1; drive(8'h7E); tick();
        lm = 1'b0; lr = 1'b0; undrive();
        er = 1'b1;
        exp_rd("rd_mar_e", 8'h1E);
        tick();
        er = 1'b0;
        rd(4'd3, 8'h7E, "rd_wr_3");
        er = 1'b1; lr = 1'b1; drive(8'h66);
        exp_st("er_lr_no_drive", 1'b0, 1'b0, 5'd5, 1'b0);
        tick();
        er = 1'b0; lr = 1'b0; undrive();
        rd(4'd3, 8'h66, "rd_er_lr_write");
        prog = 1'b1; er = 1'b1;
        exp_st("prog_blocks_er", 1'b0, 1'b0, 5'd5, 1'b0);
        tick();
        er = 1'b0; prog = 1'b0;
        tick();

        // Asynchronous reset mid-load, then reload words 0..6
        prog = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h60 + i);
            tick();
        end
        in_valid = 1'b0;
        #2;
        clr_n = 1'b0;
        exp_st("async_reset", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        clr_n = 1'b1;
        exp_st("post_reset_idle", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        exp_st("reload_entry", 1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h70 + i);
            tick();
        end
        in_valid = 1'b0; prog = 1'b0;
        tick();
        exp_st("reload_count", 1'b0, 1'b0, 5'd7, 1'b0);
        for (int i = 0; i < 7; i++) begin
            rd(4'(i), 8'(8'h70 + i), $sformatf("rd_reload_%0d", i));
        end
        rd(4'd7, 8'h17, "rd_reload_7");

        for (int i = 0; i < 10 && (st_q.size() > 0 || rd_q.size() > 0); i++) begin
            tick();
        end
        if (st_q.size() > 0 || rd_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", st_q.size() + rd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
